// File: rtl/interp_span_setup_pkg.sv
// rtl/interp_span_setup_pkg.sv - shared FSM state and rounding-mode definitions for span setup
package interp_span_setup_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_ROUND,
    S_LOAD,
    S_STEP,
    S_DONE
  } span_state_t;

  typedef enum logic [0:0] {
    RND_TRUNC,
    RND_HALF_AWAY
  } round_mode_t;

  localparam round_mode_t ROUND_MODE = RND_HALF_AWAY;

endpackage

// File: rtl/interp_span_setup_if.sv
// rtl/interp_span_setup_if.sv - span command and interpolator control bundle
interface interp_span_setup_if #(
  parameter int WIDTH = 32,
  parameter int LENW  = 16
);
  logic                    span_valid;
  logic                    span_ready;
  logic signed [WIDTH-1:0] a0;
  logic signed [WIDTH-1:0] a1;
  logic        [LENW-1:0]  len;
  logic                    out_stall;
  logic signed [WIDTH-1:0] init;
  logic signed [WIDTH-1:0] grad;
  logic                    load;
  logic                    ena;
  logic                    span_done;
  logic                    span_err;

  modport master (
    output span_valid, a0, a1, len, out_stall,
    input  span_ready, init, grad, load, ena, span_done, span_err
  );

  modport slave (
    input  span_valid, a0, a1, len, out_stall,
    output span_ready, init, grad, load, ena, span_done, span_err
  );
endinterface

// File: rtl/interp_span_setup_div.sv
// rtl/interp_span_setup_div.sv - sequential unsigned restoring divider, one quotient bit per cycle
module interp_seq_div #(
  parameter int DW   = 33,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [DW-1:0]   i_dividend,
  input  logic [LENW-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_done,
  output logic [DW-1:0]   o_quo,
  output logic [LENW-1:0] o_rem
);
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0]   r_quo;
  logic [LENW-1:0] r_rem;
  logic [LENW-1:0] r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic [LENW:0]   w_trial;
  logic            w_fit;

  // The dividend shifts out of r_quo's top while quotient bits shift in at the bottom.
  assign w_trial = {r_rem, r_quo[DW-1]};
  assign w_fit   = (w_trial >= {1'b0, r_div});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
    end else if (i_start && !r_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(DW);
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      r_quo <= {r_quo[DW-2:0], w_fit};
      r_rem <= w_fit ? LENW'(w_trial - {1'b0, r_div}) : w_trial[LENW-1:0];
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  // done marks the cycle resolving the last bit; results are valid from the next cycle on.
  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;
endmodule

// File: rtl/interp_span_setup.sv
// rtl/interp_span_setup.sv - converts a span command into init/gradient and per-pixel step control
module interp_span_setup
  import interp_span_setup_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int LENW  = 16
) (
  input logic                clk,
  input logic                rst,
  interp_span_setup_if.slave bus
);
  localparam int DW = WIDTH + 1;
  localparam logic [DW:0] POS_LIM = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic [DW:0] NEG_LIM = {3'b001, {(WIDTH-1){1'b0}}};

  if (FRAC >= WIDTH) begin : g_frac_check
    $error("FRAC must be smaller than WIDTH");
  end

  span_state_t             r_state;
  logic                    r_ready;
  logic                    r_load;
  logic                    r_done;
  logic                    r_err;
  logic                    r_neg;
  logic signed [WIDTH-1:0] r_a0;
  logic signed [WIDTH-1:0] r_init;
  logic signed [WIDTH-1:0] r_grad;
  logic [LENW-1:0]         r_len;
  logic [LENW-1:0]         r_cnt;

  logic [DW-1:0]           w_diff;
  logic [DW-1:0]           w_mag;
  logic                    w_start;
  logic                    w_div_busy;
  logic                    w_div_done;
  logic [DW-1:0]           w_quo;
  logic [LENW-1:0]         w_rem;
  logic                    w_round_up;
  logic [DW:0]             w_mag_rnd;
  logic signed [WIDTH-1:0] w_grad;
  logic                    w_last_step;

  // One extra bit keeps a1 - a0 from wrapping for any pair of inputs.
  assign w_diff  = {bus.a1[WIDTH-1], bus.a1} - {bus.a0[WIDTH-1], bus.a0};
  assign w_mag   = w_diff[WIDTH] ? DW'(-w_diff) : w_diff;
  assign w_start = (r_state == S_IDLE) && bus.span_valid && (bus.len != '0) && !w_div_busy;

  interp_seq_div #(
    .DW   (DW),
    .LENW (LENW)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend (w_mag),
    .i_divisor  (bus.len),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  assign w_round_up  = (ROUND_MODE == RND_HALF_AWAY) && ({w_rem, 1'b0} >= {1'b0, r_len});
  assign w_mag_rnd   = {1'b0, w_quo} + (DW+1)'(w_round_up);
  assign w_last_step = (r_cnt == r_len - LENW'(2));

  always_comb begin
    w_grad = '0;
    if (!r_neg) begin
      w_grad = (w_mag_rnd > POS_LIM) ? {1'b0, {(WIDTH-1){1'b1}}} : w_mag_rnd[WIDTH-1:0];
    end else begin
      w_grad = (w_mag_rnd > NEG_LIM) ? {1'b1, {(WIDTH-1){1'b0}}} : -w_mag_rnd[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_neg   <= 1'b0;
      r_a0    <= '0;
      r_init  <= '0;
      r_grad  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.span_valid) begin
            if (bus.len == '0) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_DIV;
              r_ready <= 1'b0;
              r_a0    <= bus.a0;
              r_len   <= bus.len;
              r_neg   <= w_diff[WIDTH];
            end
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= S_LOAD;
          r_load  <= 1'b1;
          r_init  <= r_a0;
          r_grad  <= w_grad;
        end
        S_LOAD: begin
          r_cnt <= '0;
          if (r_len == LENW'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          if (!bus.out_stall) begin
            r_cnt <= r_cnt + LENW'(1);
            if (w_last_step) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // ena must drop in the same cycle the interpolator stalls, so it is decoded rather than registered.
  assign bus.ena        = (r_state == S_STEP) && !bus.out_stall;
  assign bus.span_ready = r_ready;
  assign bus.init       = r_init;
  assign bus.grad       = r_grad;
  assign bus.load       = r_load;
  assign bus.span_done  = r_done;
  assign bus.span_err   = r_err;
endmodule

// File: tb/tb_interp_span_setup.sv
// tb/tb_interp_span_setup.sv - randomized self-checking bench for interp_span_setup
module tb_interp_span_setup;
  localparam int W = 32;
  localparam int L = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interp_span_setup_if #(.WIDTH(W), .LENW(L)) bus ();

  interp_span_setup #(.WIDTH(W), .FRAC(16), .LENW(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          m_loads, m_load_cyc, m_enas, m_dones, m_done_cyc, m_errs, m_err_cyc;
  int          m_stall_viol, m_excl_viol, m_busy_viol, m_hold_viol;
  logic [31:0] m_init, m_grad;
  logic        m_ready_after;

  function automatic logic [31:0] ref_grad(input logic [31:0] a0, input logic [31:0] a1, input int len);
    longint d, m, q, r;
    d = longint'($signed(a1)) - longint'($signed(a0));
    m = (d < 0) ? -d : d;
    q = m / len;
    r = m % len;
    if (2 * r >= len) q = q + 1;
    if (d < 0) q = -q;
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    if (q < -64'sd2147483648) q = -64'sd2147483648;
    return q[31:0];
  endfunction

  // stall_mode: 0 none, 1 random, 2 three stalled cycles after the second ena
  task automatic run_span(input logic [31:0] a0, input logic [31:0] a1, input logic [15:0] len,
                          input int stall_mode, input bit junk, input int rst_at, input int max_cyc);
    int  stall_until;
    int  wait_n;
    bit  ended;
    m_loads = 0; m_load_cyc = -1; m_enas = 0; m_dones = 0; m_done_cyc = -1;
    m_errs = 0; m_err_cyc = -1; m_stall_viol = 0; m_excl_viol = 0; m_busy_viol = 0;
    m_hold_viol = 0; m_init = 'x; m_grad = 'x; m_ready_after = 1'b0;
    wait_n = 0;
    @(negedge clk);
    while (!bus.span_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    n_tests++;
    if (bus.span_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait: span_ready=%b required 1", bus.span_ready);
    end
    bus.span_valid = 1'b1; bus.a0 = a0; bus.a1 = a1; bus.len = len;
    ended = 1'b0;
    stall_until = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk);
      #1;
      bus.span_valid = junk && !ended;
      if (junk) begin
        bus.a0 = $urandom; bus.a1 = $urandom; bus.len = 16'($urandom_range(0, 50));
      end
      bus.out_stall = (stall_mode == 1) ? ($urandom_range(0, 2) == 0) : (stall_mode == 2 && k <= stall_until);
      rst = (k == rst_at);
      @(negedge clk);
      if (bus.load) begin
        m_loads++; m_load_cyc = k; m_init = bus.init; m_grad = bus.grad;
      end else if (m_loads > 0 && (bus.init !== m_init || bus.grad !== m_grad)) begin
        m_hold_viol++;
      end
      if (bus.ena) begin
        m_enas++;
        if (bus.out_stall) m_stall_viol++;
        if (stall_mode == 2 && m_enas == 2) stall_until = k + 3;
      end
      if (bus.span_done) begin m_dones++; m_done_cyc = k; end
      if (bus.span_err) begin m_errs++; m_err_cyc = k; end
      if (int'(bus.load) + int'(bus.ena) + int'(bus.span_done) + int'(bus.span_err) > 1) m_excl_viol++;
      if (ended) begin
        m_ready_after = bus.span_ready;
        break;
      end
      if (bus.span_done || bus.span_err) ended = 1'b1;
      else if (bus.span_ready && (rst_at == 0 || k < rst_at)) m_busy_viol++;
    end
    bus.span_valid = 1'b0;
    bus.out_stall  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.span_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.span_ready); end
    n_tests++; if (bus.init !== 32'sd0) begin n_fail++; $display("FAIL reset_init: got %h expected 0", bus.init); end
    n_tests++; if (bus.grad !== 32'sd0) begin n_fail++; $display("FAIL reset_grad: got %h expected 0", bus.grad); end
    n_tests++;
    if ({bus.load, bus.ena, bus.span_done, bus.span_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {bus.load, bus.ena, bus.span_done, bus.span_err});
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic_span();
    run_span(32'h0, 32'h000A0000, 16'd4, 0, 1'b0, 0, 100);
    n_tests++; if (m_grad !== 32'h00028000) begin n_fail++; $display("FAIL basic_grad: got %h expected 00028000", m_grad); end
    n_tests++; if (m_init !== 32'h0) begin n_fail++; $display("FAIL basic_init: got %h expected 0", m_init); end
    n_tests++; if (m_load_cyc !== 35) begin n_fail++; $display("FAIL basic_load_cycle: got %0d expected 35", m_load_cyc); end
    n_tests++; if (m_enas !== 3) begin n_fail++; $display("FAIL basic_ena_count: got %0d expected 3", m_enas); end
    n_tests++; if (m_done_cyc !== 39 || m_dones !== 1) begin n_fail++; $display("FAIL basic_done: got cycle %0d count %0d expected 39/1", m_done_cyc, m_dones); end
    n_tests++; if (m_ready_after !== 1'b1 || m_busy_viol !== 0) begin n_fail++; $display("FAIL basic_ready: after=%b busy_viol=%0d expected 1/0", m_ready_after, m_busy_viol); end
  endtask

  task automatic test_rounding();
    run_span(32'h0, 32'h1, 16'd2, 0, 1'b0, 0, 100);
    n_tests++; if (m_grad !== 32'h1) begin n_fail++; $display("FAIL round_pos: got %h expected 00000001", m_grad); end
    run_span(32'h0, 32'hFFFFFFFF, 16'd2, 0, 1'b0, 0, 100);
    n_tests++; if (m_grad !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL round_neg: got %h expected ffffffff", m_grad); end
    n_tests++; if (m_enas !== 1) begin n_fail++; $display("FAIL round_ena_count: got %0d expected 1", m_enas); end
  endtask

  task automatic test_saturate();
    run_span(32'h80000000, 32'h7FFFFFFF, 16'd1, 0, 1'b0, 0, 100);
    n_tests++; if (m_grad !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL sat_pos_grad: got %h expected 7fffffff", m_grad); end
    n_tests++; if (m_enas !== 0) begin n_fail++; $display("FAIL sat_pos_ena: got %0d expected 0", m_enas); end
    n_tests++; if (m_done_cyc !== m_load_cyc + 1 || m_dones !== 1) begin n_fail++; $display("FAIL sat_pos_done: done %0d load %0d expected done=load+1", m_done_cyc, m_load_cyc); end
    run_span(32'h7FFFFFFF, 32'h80000000, 16'd1, 0, 1'b0, 0, 100);
    n_tests++; if (m_grad !== 32'h80000000) begin n_fail++; $display("FAIL sat_neg_grad: got %h expected 80000000", m_grad); end
  endtask

  task automatic test_len_zero();
    run_span(32'h5, 32'h9, 16'd0, 0, 1'b0, 0, 100);
    n_tests++; if (m_errs !== 1 || m_err_cyc !== 1) begin n_fail++; $display("FAIL lenzero_err: count %0d cycle %0d expected 1/1", m_errs, m_err_cyc); end
    n_tests++; if (m_loads + m_enas + m_dones !== 0) begin n_fail++; $display("FAIL lenzero_quiet: load %0d ena %0d done %0d expected 0", m_loads, m_enas, m_dones); end
    n_tests++; if (m_ready_after !== 1'b1) begin n_fail++; $display("FAIL lenzero_ready: got %b expected 1", m_ready_after); end
    n_tests++;
    if (bus.init !== 32'sh7FFFFFFF || bus.grad !== 32'sh80000000) begin
      n_fail++; $display("FAIL lenzero_hold: init %h grad %h expected 7fffffff/80000000", bus.init, bus.grad);
    end
  endtask

  task automatic test_stall();
    run_span(32'h0, 32'h00050000, 16'd5, 2, 1'b0, 0, 100);
    n_tests++; if (m_enas !== 4) begin n_fail++; $display("FAIL stall_ena_count: got %0d expected 4", m_enas); end
    n_tests++; if (m_stall_viol !== 0) begin n_fail++; $display("FAIL stall_ena_while_stalled: got %0d expected 0", m_stall_viol); end
    n_tests++; if (m_done_cyc !== 43) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 43", m_done_cyc); end
    n_tests++; if (m_grad !== 32'h00010000) begin n_fail++; $display("FAIL stall_grad: got %h expected 00010000", m_grad); end
  endtask

  task automatic test_reset_mid_div();
    run_span(32'h0, 32'h00100000, 16'd3, 0, 1'b0, 10, 60);
    n_tests++; if (m_loads + m_enas + m_dones !== 0) begin n_fail++; $display("FAIL rstdiv_quiet: load %0d ena %0d done %0d expected 0", m_loads, m_enas, m_dones); end
    @(negedge clk);
    n_tests++; if (bus.init !== 32'sd0 || bus.grad !== 32'sd0) begin n_fail++; $display("FAIL rstdiv_regs: init %h grad %h expected 0/0", bus.init, bus.grad); end
    n_tests++; if (bus.span_ready !== 1'b1) begin n_fail++; $display("FAIL rstdiv_ready: got %b expected 1", bus.span_ready); end
    run_span(32'h0, 32'h00300000, 16'd3, 0, 1'b0, 0, 100);
    n_tests++; if (m_grad !== 32'h00100000 || m_load_cyc !== 35) begin n_fail++; $display("FAIL rstdiv_next: grad %h load %0d expected 00100000/35", m_grad, m_load_cyc); end
    n_tests++; if (m_enas !== 2 || m_dones !== 1) begin n_fail++; $display("FAIL rstdiv_next_steps: ena %0d done %0d expected 2/1", m_enas, m_dones); end
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] a0, a1, exp;
    logic [15:0] len;
    for (int i = 0; i < 25; i++) begin
      a0 = $urandom;
      if ($urandom_range(0, 1) == 1) a1 = $urandom;
      else a1 = a0 + {20'd0, 12'($urandom)} - 32'd2048;
      len = 16'($urandom_range(1, 12));
      exp = ref_grad(a0, a1, int'(len));
      run_span(a0, a1, len, 1, 1'b1, 0, 200);
      n_tests++; if (m_grad !== exp) begin n_fail++; $display("FAIL rnd%0d_grad: got %h expected %h (a0 %h a1 %h len %0d)", i, m_grad, exp, a0, a1, len); end
      n_tests++; if (m_init !== a0) begin n_fail++; $display("FAIL rnd%0d_init: got %h expected %h", i, m_init, a0); end
      n_tests++; if (m_load_cyc !== 35 || m_loads !== 1) begin n_fail++; $display("FAIL rnd%0d_load: cycle %0d count %0d expected 35/1", i, m_load_cyc, m_loads); end
      n_tests++; if (m_enas !== int'(len) - 1) begin n_fail++; $display("FAIL rnd%0d_ena_count: got %0d expected %0d", i, m_enas, int'(len) - 1); end
      n_tests++; if (m_dones !== 1 || m_errs !== 0) begin n_fail++; $display("FAIL rnd%0d_done: done %0d err %0d expected 1/0", i, m_dones, m_errs); end
      n_tests++; if (m_stall_viol !== 0 || m_excl_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_exclusive: stall_viol %0d excl_viol %0d expected 0/0", i, m_stall_viol, m_excl_viol); end
      n_tests++; if (m_busy_viol !== 0 || m_hold_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_busy_hold: busy_viol %0d hold_viol %0d expected 0/0", i, m_busy_viol, m_hold_viol); end
    end
  endtask

  initial begin
    bus.span_valid = 1'b0;
    bus.a0 = '0;
    bus.a1 = '0;
    bus.len = '0;
    bus.out_stall = 1'b0;
    test_reset();
    test_basic_span();
    test_rounding();
    test_saturate();
    test_len_zero();
    test_stall();
    test_reset_mid_div();
    test_random_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/interp_span_setup.md
INTERP_SPAN_SETUP -- requirements
Module: interp_span_setup

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning signed attribute width in Q(WIDTH-FRAC-1).FRAC.
REQ-002 SHALL have parameter FRAC, default 16, meaning fractional bits; informational only, since the arithmetic is format-agnostic.
REQ-003 SHALL have parameter LENW, default 16, meaning span-length width in pixels.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 span_valid  in  1  span command offered.
REQ-008 span_ready  out  1  block idle and accepting a command.
REQ-009 a0  in  WIDTH signed  attribute value at span start.
REQ-010 a1  in  WIDTH signed  attribute value at span end.
REQ-011 len  in  LENW unsigned  span pixel count.
REQ-012 out_stall  in  1  downstream interpolator busy; blocks stepping.
REQ-013 init  out  WIDTH signed  start value for the interpolator.
REQ-014 grad  out  WIDTH signed  per-pixel gradient for the interpolator.
REQ-015 load  out  1  one-cycle pulse that loads init downstream.
REQ-016 ena  out  1  advance the downstream interpolator by one pixel.
REQ-017 span_done  out  1  one-cycle pulse when the span is finished.
REQ-018 span_err  out  1  one-cycle pulse when len==0 is rejected.

Function
REQ-019 SHALL implement the FSM states IDLE, DIV, ROUND, LOAD, STEP and DONE.
REQ-020 IDLE SHALL assert span_ready; on span_valid&&span_ready, SHALL capture a0, a1 and len.
REQ-021 On capture with len==0, SHALL pulse span_err on the next cycle and return to IDLE, with no load, no ena, no span_done, and init/grad unchanged.
REQ-022 On capture with len!=0, SHALL form diff = a1 - a0 at WIDTH+1 bits (no wrap) and latch sign(diff) and |diff|.
REQ-023 DIV SHALL run an unsigned restoring divide |diff|/len, one quotient bit per cycle, for exactly WIDTH+1 cycles.
REQ-024 ROUND (1 cycle) SHALL round half away from zero: if 2*rem >= len, add 1 to the magnitude; it SHALL then reapply the sign.
REQ-025 ROUND SHALL saturate the result to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-026 LOAD (1 cycle) SHALL assert load, with init=a0 and grad=the rounded result, both valid in the same cycle.
REQ-027 init and grad SHALL hold stable from LOAD until the next capture.
REQ-028 Latency: acceptance at cycle T gives DIV at T+1..T+WIDTH+1, ROUND at T+WIDTH+2 and load at T+WIDTH+3.
REQ-029 STEP SHALL assert ena on each cycle where !out_stall, until len-1 ena pulses have been issued; len==1 goes from LOAD straight to DONE.
REQ-030 ena SHALL NOT be asserted while out_stall=1; out_stall SHALL NOT affect DIV, ROUND or LOAD.
REQ-031 DONE SHALL pulse span_done for 1 cycle and then return to IDLE.
REQ-032 span_ready SHALL be low in every state except IDLE; commands presented while busy are not captured.
REQ-033 load, ena, span_done and span_err SHALL be mutually exclusive in any cycle.

Reset
REQ-034 When rst=1, next cycle SHALL be IDLE with span_ready=1, init=0, grad=0 and load/ena/span_done/span_err=0.
REQ-035 Reset asserted mid-DIV or mid-STEP SHALL abandon the span, with no further load, ena or done; rst has priority over all inputs.

Structure
REQ-036 The FSM state enum and the rounding-mode constant SHALL live in the shared interp package.
REQ-037 The divider SHALL be a sub-module, interp_seq_div: start/busy/done handshake, unsigned WIDTH+1 by LENW, returning quotient and remainder.

Verification
REQ-038 a0=0, a1=0x000A0000, len=4 -> grad=0x00028000, init=0; load at T+35; 3 ena; span_done.
REQ-039 a0=0, a1=1, len=2 -> grad=1; a0=0, a1=-1, len=2 -> grad=-1 (half away from zero).
REQ-040 a0=0x80000000, a1=0x7FFFFFFF, len=1 -> grad=0x7FFFFFFF (saturated); no ena; span_done right after load.
REQ-041 len=0 -> span_err pulse only; no load; span_ready back high next cycle.
REQ-042 len=5 with out_stall high for 3 cycles after the 2nd ena -> exactly 4 ena total; none while stalled.
REQ-043 rst pulsed at T+10 (mid-DIV) -> no load/ena/done; next command processes normally.
